// File: rtl/des_key_pkg.sv
// des_key_pkg: shared types, tables and helpers for the DES key schedule sequencer.
//   state_e        - sequencer states (idle, load, shift, present)
//   SCHED / RSCHED - per-round rotate amounts (left for encrypt, right for decrypt)
//   PC1 / PC2      - DES permutation tables, entry n holds the 1-based source bit of output n+1
//   rot28          - 28-bit half rotate by 0/1/2 in either direction
package des_key_pkg;

    localparam int unsigned KEY_W    = 64;
    localparam int unsigned HALF_W   = 28;
    localparam int unsigned SUBKEY_W = 48;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StPresent
    } state_e;

    localparam logic [1:0] SCHED [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // First decrypt round needs no rotation: after a full schedule C/D are back at K16.
    localparam logic [1:0] RSCHED [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // MSB of the half is DES bit 1, so a DES left shift moves bits toward the MSB.
    function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] x,
                                                input logic [1:0]        amt,
                                                input logic              right);
        logic [HALF_W-1:0] r;
        r = x;
        if (right) begin
            case (amt)
                2'd1:    r = {x[0], x[27:1]};
                2'd2:    r = {x[1:0], x[27:2]};
                default: r = x;
            endcase
        end else begin
            case (amt)
                2'd1:    r = {x[26:0], x[27]};
                2'd2:    r = {x[25:0], x[27:26]};
                default: r = x;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// des_pc2: combinational DES PC-2 permutation, 56-bit {C,D} to 48-bit subkey.
//   cd_i     - {C,D}, cd_i[55] is DES bit 1
//   subkey_o - PC-2 result, subkey_o[47] is PC-2 output bit 1
module des_pc2
    import des_key_pkg::*;
(
    input  logic [2*HALF_W-1:0] cd_i,
    output logic [SUBKEY_W-1:0] subkey_o
);

    always_comb begin
        subkey_o = '0;
        for (int j = 0; j < int'(SUBKEY_W); j++) begin
            subkey_o[6'(int'(SUBKEY_W) - 1 - j)] = cd_i[6'(int'(2 * HALF_W) - int'(PC2[j]))];
        end
    end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl: DES key schedule sequencer.
// Loads a 64-bit key through PC-1, then for each of 16 rounds rotates C/D and presents
// the PC-2 subkey on a valid/ready handshake. done pulses one cycle after the last handshake.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   start, key_in         - load request (taken only when ready) and key, key_in[63] = DES bit 1
//   abort                 - synchronous cancel of a schedule in progress
//   ready                 - high in idle
//   subkey_valid/_ready   - subkey handshake; subkey and round held until accepted
//   subkey, round         - PC-2(C,D) and subkey index 0..15
//   done                  - completion pulse
// Build option DES_DECRYPT_EN adds input decrypt (sampled with start) for K16..K1 order.
module des_key_sched_ctrl
    import des_key_pkg::*;
#(
    parameter int unsigned NROUNDS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                abort,
`ifdef DES_DECRYPT_EN
    input  logic                decrypt,
`endif
    output logic                ready,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic [3:0]          round,
    output logic                done
);

    state_e            state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              dec_q;
`ifdef DES_DECRYPT_EN
    logic              dec_d;
`else
    assign dec_q = 1'b0;
`endif

    logic [2*HALF_W-1:0] pc1_key;
    logic [1:0]          rot_amt;
    logic                handshake;

    always_comb begin
        pc1_key = '0;
        for (int i = 0; i < 56; i++) begin
            pc1_key[6'(55 - i)] = key_in[6'(64 - int'(PC1[i]))];
        end
    end

    assign handshake = subkey_valid & subkey_ready;
    assign rot_amt   = dec_q ? RSCHED[cnt_q] : SCHED[cnt_q];

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef DES_DECRYPT_EN
        dec_d   = dec_q;
`endif
        unique case (state_q)
            StIdle: begin
                // abort alongside start in idle suppresses the start
                if (start && !abort) begin
                    state_d = StLoad;
                    c_d     = pc1_key[55:28];
                    d_d     = pc1_key[27:0];
                    cnt_d   = '0;
`ifdef DES_DECRYPT_EN
                    dec_d   = decrypt;
`endif
                end
            end
            StLoad:  state_d = StShift;
            StShift: begin
                c_d     = rot28(c_q, rot_amt, dec_q);
                d_d     = rot28(d_q, rot_amt, dec_q);
                state_d = StPresent;
            end
            StPresent: begin
                if (handshake) begin
                    if (cnt_q == 4'(NROUNDS - 1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = StShift;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            c_d     = c_q;
            d_d     = d_q;
            cnt_d   = cnt_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef DES_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef DES_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

    des_pc2 u_pc2 (
        .cd_i     ({c_q, d_q}),
        .subkey_o (subkey)
    );

    assign ready        = (state_q == StIdle);
    assign subkey_valid = (state_q == StPresent);
    assign round        = dec_q ? ~cnt_q : cnt_q;
    assign done         = done_q;

endmodule
